// File: rtl/operand2_sequencer.sv
// operand2_sequencer
//   Sequences the second ALU operand for SPARC format-3 instructions. An
//   accepted instruction selects either the sign-extended simm13 (through
//   the external sign-extender) or register rs2 (through a req/ack read of
//   the register file). The 32-bit result is offered to execute under a
//   valid/taken handshake.
//
//   Optional feature macro: SETHI_EN -- when defined, SETHI (op=00,
//   op2=100) produces {imm22,10'b0} directly with isImmediate set.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   instrValid/instr/instrReady       instruction accept handshake
//   rfReadReq/rfReadAddr/rfReadAck/rfReadData  register file read port
//   seInput/seOutput                  sign-extender drive and result
//   operandValid/operand2/operandTaken operand handshake to execute
//   isImmediate     operand2 came from an immediate field
//   rfError         register read timed out (operand2 forced to 0)
module operand2_sequencer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instrValid,
  input  logic [31:0] instr,
  output logic        instrReady,
  output logic        rfReadReq,
  output logic [4:0]  rfReadAddr,
  input  logic        rfReadAck,
  input  logic [31:0] rfReadData,
  output logic [12:0] seInput,
  input  logic [31:0] seOutput,
  output logic        operandValid,
  output logic [31:0] operand2,
  input  logic        operandTaken,
  output logic        isImmediate,
  output logic        rfError
);

  typedef enum logic [1:0] {IDLE, EXT, REQ, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [12:0]        simm_q;
  logic [4:0]         rs2_q;
  logic [31:0]        op2_q;
  logic               imm_q;
  logic               err_q;

  // Accept-edge decode, taken straight from the incoming word.
  logic fmt3, i_bit, rs2_zero;
  assign fmt3     = instr[31];      // op in {10,11}
  assign i_bit    = instr[13];
  assign rs2_zero = (instr[4:0] == 5'd0);

`ifdef SETHI_EN
  logic is_sethi;
  assign is_sethi = (instr[31:30] == 2'b00) && (instr[24:22] == 3'b100);
`endif

  // Only some instruction fields matter; fold the rest away.
  logic unused_instr;
  assign unused_instr = ^instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      simm_q  <= '0;
      rs2_q   <= '0;
      op2_q   <= '0;
      imm_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (instrValid) begin
            simm_q <= instr[12:0];
            rs2_q  <= instr[4:0];
            op2_q  <= '0;
            imm_q  <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
            if (fmt3 && i_bit) begin
              imm_q   <= 1'b1;
              state_q <= EXT;
            end else if (fmt3 && !rs2_zero) begin
              state_q <= REQ;
`ifdef SETHI_EN
            end else if (is_sethi) begin
              op2_q   <= {instr[21:0], 10'b0};
              imm_q   <= 1'b1;
              state_q <= DONE;
`endif
            end else begin
              // %g0 reads and non-format-3 ops complete with zero.
              state_q <= DONE;
            end
          end
        end
        EXT: begin
          // seInput has held the latched simm13 for the whole cycle.
          op2_q   <= seOutput;
          state_q <= DONE;
        end
        REQ: begin
          if (rfReadAck) begin
            op2_q   <= rfReadData;
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            op2_q   <= '0;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (operandTaken) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instrReady   = (state_q == IDLE);
  assign rfReadReq    = (state_q == REQ);
  assign operandValid = (state_q == DONE);
  assign rfReadAddr   = rs2_q;
  assign seInput      = simm_q;
  assign operand2     = op2_q;
  assign isImmediate  = imm_q;
  assign rfError      = err_q;

endmodule

// File: tb/tb_operand2_sequencer.sv
// Self-checking bench for operand2_sequencer: directed scenarios from the
// test plan followed by randomized transactions against a reference model.
module tb_operand2_sequencer;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        instrValid;
  logic [31:0] instr;
  logic        instrReady;
  logic        rfReadReq;
  logic [4:0]  rfReadAddr;
  logic        rfReadAck;
  logic [31:0] rfReadData;
  logic [12:0] seInput;
  logic [31:0] seOutput;
  logic        operandValid;
  logic [31:0] operand2;
  logic        operandTaken;
  logic        isImmediate;
  logic        rfError;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // External sign-extender.
  assign seOutput = {{19{seInput[12]}}, seInput};

  operand2_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .instrValid(instrValid), .instr(instr), .instrReady(instrReady),
    .rfReadReq(rfReadReq), .rfReadAddr(rfReadAddr),
    .rfReadAck(rfReadAck), .rfReadData(rfReadData),
    .seInput(seInput), .seOutput(seOutput),
    .operandValid(operandValid), .operand2(operand2),
    .operandTaken(operandTaken),
    .isImmediate(isImmediate), .rfError(rfError)
  );

  // Reference: expected result for instruction ins whose register read
  // (if any) is acked d cycles into REQ with value data (d >= TO: never).
  // lat = cycles from the accept edge to operandValid.
  function automatic void model(input logic [31:0] ins, input int d,
                                input logic [31:0] data,
                                output logic [31:0] op2, output logic imm,
                                output logic err, output int lat,
                                output logic req);
    int v;
    op2 = 0; imm = 0; err = 0; lat = 1; req = 0;
    if (ins[31]) begin
      if (ins[13]) begin
        v = int'(ins[12:0]);
        if (v >= 4096) v = v - 8192;
        op2 = v; imm = 1; lat = 2;
      end else if (ins[4:0] != 0) begin
        req = 1;
        if (d < TO) begin op2 = data; lat = d + 2; end
        else begin err = 1; lat = TO + 1; end
      end
    end
`ifdef SETHI_EN
    else if (ins[31:30] == 2'b00 && ins[24:22] == 3'b100) begin
      op2 = ins[21:0] * 1024; imm = 1;
    end
`endif
  endfunction

  task automatic tick();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic accept(input logic [31:0] ins);
    instrValid = 1'b1; instr = ins;
    tick();
    instrValid = 1'b0; instr = $urandom;
  endtask

  task automatic take();
    operandTaken = 1'b1;
    tick();
    operandTaken = 1'b0;
  endtask

  task automatic test_reset();
    logic [54:0] obs;
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    obs = {instrReady, rfReadReq, rfReadAddr, seInput, operandValid,
           operand2, isImmediate, rfError};
    checks++;
    if (obs !== {1'b1, 54'b0}) begin
      errors++; $display("FAIL reset_state got=%h want=%h", obs, {1'b1, 54'b0});
    end
  endtask

  task automatic test_immediate();
    logic [31:0] ins [2];
    logic [31:0] exp [2];
    ins[0] = 32'h8200_3FFF; exp[0] = 32'hFFFF_FFFF;
    ins[1] = 32'h8200_2FFF; exp[1] = 32'h0000_0FFF;
    for (int k = 0; k < 2; k++) begin
      accept(ins[k]);
      checks++;
      if (seInput !== ins[k][12:0] || operandValid !== 1'b0) begin
        errors++; $display("FAIL imm_ext_cycle se=%h vld=%b want se=%h vld=0",
                           seInput, operandValid, ins[k][12:0]);
      end
      tick();
      checks++;
      if (operandValid !== 1'b1 || operand2 !== exp[k] || isImmediate !== 1'b1) begin
        errors++; $display("FAIL imm_result vld=%b op2=%h imm=%b want 1 %h 1",
                           operandValid, operand2, isImmediate, exp[k]);
      end
      take();
    end
  endtask

  task automatic test_register();
    logic [31:0] held;
    accept(32'h8200_0005);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rfReadReq !== 1'b1 || rfReadAddr !== 5'd5 || operandValid !== 1'b0) begin
        errors++; $display("FAIL reg_req cyc=%0d req=%b addr=%0d vld=%b want 1 5 0",
                           k, rfReadReq, rfReadAddr, operandValid);
      end
      if (k == 3) begin rfReadAck = 1'b1; rfReadData = 32'hDEAD_BEEF; end
      tick();
    end
    rfReadAck = 1'b0; rfReadData = $urandom;
    checks++;
    if (operandValid !== 1'b1 || operand2 !== 32'hDEAD_BEEF || rfReadReq !== 1'b0 ||
        isImmediate !== 1'b0 || rfError !== 1'b0) begin
      errors++; $display("FAIL reg_result vld=%b op2=%h req=%b imm=%b err=%b want 1 deadbeef 0 0 0",
                         operandValid, operand2, rfReadReq, isImmediate, rfError);
    end
    held = operand2;
    for (int k = 0; k < 3; k++) begin
      rfReadAck = 1'b1;
      tick();
      checks++;
      if (operandValid !== 1'b1 || operand2 !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL reg_hold cyc=%0d vld=%b op2=%h want 1 deadbeef",
                           k, operandValid, operand2);
      end
    end
    rfReadAck = 1'b0;
    take();
    checks++;
    if (instrReady !== 1'b1 || operandValid !== 1'b0 || operand2 !== held) begin
      errors++; $display("FAIL reg_taken rdy=%b vld=%b op2=%h want 1 0 %h",
                         instrReady, operandValid, operand2, held);
    end
  endtask

  task automatic test_g0();
    accept(32'h8200_0000);
    checks++;
    if (operandValid !== 1'b1 || operand2 !== 32'h0 || rfReadReq !== 1'b0) begin
      errors++; $display("FAIL g0 vld=%b op2=%h req=%b want 1 0 0",
                         operandValid, operand2, rfReadReq);
    end
    take();
  endtask

  task automatic test_timeout();
    int reqc = 0;
    accept(32'h8200_0007);
    while (operandValid !== 1'b1 && reqc < 40) begin
      if (rfReadReq === 1'b1) reqc++;
      tick();
    end
    checks++;
    if (reqc != TO || operandValid !== 1'b1 || rfError !== 1'b1 || operand2 !== 32'h0) begin
      errors++; $display("FAIL timeout reqcycles=%0d vld=%b err=%b op2=%h want %0d 1 1 0",
                         reqc, operandValid, rfError, operand2, TO);
    end
    take();
    checks++;
    if (rfError !== 1'b1) begin
      errors++; $display("FAIL err_hold got=%b want 1", rfError);
    end
    accept(32'h8200_0000);
    checks++;
    if (rfError !== 1'b0) begin
      errors++; $display("FAIL err_clear got=%b want 0", rfError);
    end
    take();
  endtask

  task automatic test_reset_mid_req();
    logic [54:0] obs;
    accept(32'h8200_0007);
    tick(); tick();
    checks++;
    if (rfReadReq !== 1'b1) begin
      errors++; $display("FAIL midreq_pre req=%b want 1", rfReadReq);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    obs = {instrReady, rfReadReq, rfReadAddr, seInput, operandValid,
           operand2, isImmediate, rfError};
    checks++;
    if (obs !== {1'b1, 54'b0}) begin
      errors++; $display("FAIL midreq_reset got=%h want=%h", obs, {1'b1, 54'b0});
    end
    rfReadAck = 1'b1; rfReadData = 32'h1234_5678;
    tick();
    rfReadAck = 1'b0;
    tick();
    checks++;
    if (instrReady !== 1'b1 || operandValid !== 1'b0 || operand2 !== 32'h0) begin
      errors++; $display("FAIL late_ack rdy=%b vld=%b op2=%h want 1 0 0",
                         instrReady, operandValid, operand2);
    end
  endtask

  task automatic test_sethi();
    logic [31:0] eop; logic eimm;
`ifdef SETHI_EN
    eop = 32'h0000_0400; eimm = 1'b1;
`else
    eop = 32'h0; eimm = 1'b0;
`endif
    accept(32'h0300_0001);
    checks++;
    if (operandValid !== 1'b1 || operand2 !== eop || isImmediate !== eimm) begin
      errors++; $display("FAIL sethi vld=%b op2=%h imm=%b want 1 %h %b",
                         operandValid, operand2, isImmediate, eop, eimm);
    end
    take();
  endtask

  task automatic test_random();
    logic [31:0] ins, data, eop, held;
    logic eimm, eerr, ereq, seen_req;
    int d, elat, lat, reqk, gap, cls;
    for (int n = 0; n < 80; n++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        rfReadAck = 1'($urandom); operandTaken = 1'($urandom);
        tick();
      end
      rfReadAck = 1'b0; operandTaken = 1'b0;
      ins = $urandom; cls = $urandom_range(0, 4);
      case (cls)
        0: begin ins[31] = 1'b1; ins[13] = 1'b1; end
        1: begin ins[31] = 1'b1; ins[13] = 1'b0; if (ins[4:0] == 0) ins[4:0] = 5'd1; end
        2: begin ins[31] = 1'b1; ins[13] = 1'b0; ins[4:0] = 5'd0; end
        3: ins[31] = 1'b0;
        default: begin ins[31:30] = 2'b00; ins[24:22] = 3'b100; end
      endcase
      d = $urandom_range(0, 18); data = $urandom;
      model(ins, d, data, eop, eimm, eerr, elat, ereq);
      checks++;
      if (instrReady !== 1'b1) begin
        errors++; $display("FAIL rnd_ready n=%0d got=%b want 1", n, instrReady);
      end
      accept(ins);
      lat = 99; reqk = 0; seen_req = 1'b0;
      for (int c = 1; c <= 40; c++) begin
        if (operandValid === 1'b1) begin lat = c; break; end
        if (rfReadReq === 1'b1) begin
          seen_req = 1'b1;
          if (rfReadAddr !== ins[4:0]) begin
            errors++; $display("FAIL rnd_addr n=%0d got=%0d want %0d", n, rfReadAddr, ins[4:0]);
          end
          rfReadAck = (reqk == d);
          rfReadData = (reqk == d) ? data : $urandom;
          reqk++;
        end
        tick();
        rfReadAck = 1'b0;
      end
      checks++;
      if (lat != elat || operand2 !== eop || isImmediate !== eimm ||
          rfError !== eerr || seen_req !== ereq) begin
        errors++;
        $display("FAIL rnd_txn n=%0d ins=%h lat=%0d op2=%h imm=%b err=%b req=%b want %0d %h %b %b %b",
                 n, ins, lat, operand2, isImmediate, rfError, seen_req, elat, eop, eimm, eerr, ereq);
      end
      held = operand2;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        rfReadAck = 1'($urandom); rfReadData = $urandom;
        tick();
      end
      rfReadAck = 1'b0;
      checks++;
      if (operandValid !== 1'b1 || operand2 !== held) begin
        errors++; $display("FAIL rnd_hold n=%0d vld=%b op2=%h want 1 %h", n, operandValid, operand2, held);
      end
      take();
    end
  endtask

  initial begin
    reset = 1'b1; instrValid = 1'b0; instr = '0; rfReadAck = 1'b0;
    rfReadData = '0; operandTaken = 1'b0;
    @(negedge clk);
    test_reset();
    test_immediate();
    test_register();
    test_g0();
    test_timeout();
    test_reset_mid_req();
    test_sethi();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
